alu_result_fifo: RTL and testbench

Downstream stage of the simple ALU: it captures every `q`/`out_vld` result and buffers it in a DEPTH-entry FIFO. Results leave on a valid/ready master port, so a consumer that stalls does not need to run in lockstep with the ALU. The ALU cannot be back-pressured, so results arriving while the FIFO is full are dropped and flagged with a sticky overflow bit.

---
 rtl/alu_result_fifo.sv | 107 ++++++++++
 tb/tb_alu_result_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result buffer behind the ALU: captures q/out_vld into a DEPTH-entry FWFT FIFO
// with a valid/ready drain port. Define ALU_RES_FIFO_STATS_EN to add drop_cnt.

module alu_result_fifo_entry #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  // Storage only; contents are deliberately left unreset.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_vld,
  output logic [DW-1:0]            m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     ovf,
  input  logic                     clr_ovf
`ifdef ALU_RES_FIFO_STATS_EN
  , output logic [15:0]            drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] data;
  } res_req_t;

  res_req_t                  req;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [LW-1:0]             level_q;
  logic [DEPTH-1:0][DW-1:0]  mem;
  logic [DEPTH-1:0]          we;
  logic                      push, pop, drop;

  assign req = '{vld: in_vld, data: in_data};

  // Status is decoded from the registered level only, so no input reaches it.
  assign level   = level_q;
  assign full    = (level_q == LW'(DEPTH));
  assign m_valid = (level_q != '0);
  assign m_data  = mem[rd_ptr];

  assign pop  = m_valid & m_ready;
  assign push = req.vld & (~full | pop);
  assign drop = req.vld & full & ~pop;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign we[i] = push & (wr_ptr == AW'(i));
    alu_result_fifo_entry #(.DW(DW)) u_ent (
      .clk (clk),
      .we  (we[i]),
      .d   (req.data),
      .q   (mem[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

`ifdef ALU_RES_FIFO_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_cnt <= '0;
    else if (clr_ovf)
      drop_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo at DEPTH=4; checks on the falling edge.

module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_vld;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [2:0]    level;
  logic          full;
  logic          ovf;
  logic          clr_ovf;
`ifdef ALU_RES_FIFO_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_vld  (in_vld),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level),
    .full    (full),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
`ifdef ALU_RES_FIFO_STATS_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    reset_n = 1'b1; in_data = '0; in_vld = 0; m_ready = 0; clr_ovf = 0;
    #1 reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_full",  full,  0);
    chk("rst_ovf",   ovf,   0);

    // three pushes with consumer stalled, then drain in order
    in_vld = 1; in_data = 8'h11; cyc();
    chk("p1_level", level, 1);
    chk("p1_valid", m_valid, 1);
    chk("p1_data",  m_data, 8'h11);
    in_data = 8'h22; cyc();
    in_data = 8'h33; cyc();
    in_vld = 0;
    chk("p3_level", level, 3);
    chk("p3_hold",  m_data, 8'h11);
    m_ready = 1; cyc();
    chk("pop1_data",  m_data, 8'h22);
    chk("pop1_level", level, 2);
    cyc();
    chk("pop2_data",  m_data, 8'h33);
    chk("pop2_level", level, 1);
    cyc();
    chk("pop3_level", level, 0);
    chk("pop3_valid", m_valid, 0);
    m_ready = 0;

    // fill, then overflow drop
    in_vld = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i); cyc();
    end
    chk("fill_full",  full, 1);
    chk("fill_level", level, 4);
    in_data = 8'hAA; cyc();
    in_vld = 0;
    chk("drop_full",  full, 1);
    chk("drop_ovf",   ovf, 1);
    chk("drop_level", level, 4);
    chk("drop_head",  m_data, 8'h01);
`ifdef ALU_RES_FIFO_STATS_EN
    chk("drop_cnt1", drop_cnt, 1);
`endif

    // clear alone, then clear with a simultaneous drop
    clr_ovf = 1; cyc();
    clr_ovf = 0;
    chk("clr_ovf", ovf, 0);
`ifdef ALU_RES_FIFO_STATS_EN
    chk("clr_cnt", drop_cnt, 0);
`endif
    clr_ovf = 1; in_vld = 1; in_data = 8'hAA; cyc();
    clr_ovf = 0; in_vld = 0;
    chk("clrdrop_ovf", ovf, 1);
`ifdef ALU_RES_FIFO_STATS_EN
    chk("clrdrop_cnt", drop_cnt, 1);
`endif
    clr_ovf = 1; cyc();
    clr_ovf = 0;
    chk("clr2_ovf", ovf, 0);

    // full with simultaneous push and pop
    in_vld = 1; in_data = 8'hBB; m_ready = 1; cyc();
    in_vld = 0;
    chk("swap_level", level, 4);
    chk("swap_full",  full, 1);
    chk("swap_ovf",   ovf, 0);
    chk("swap_head",  m_data, 8'h02);
    cyc(); chk("swap_d3", m_data, 8'h03);
    cyc(); chk("swap_d4", m_data, 8'h04);
    cyc(); chk("swap_bb", m_data, 8'hBB);
    cyc();
    chk("swap_empty", m_valid, 0);

    // streaming across pointer wrap
    in_vld = 1;
    for (int i = 0; i < 20; i++) begin
      d = 8'(i * 7 + 3);
      in_data = d; cyc();
      chk("str_data",  m_data, d);
      chk("str_level", level, 1);
    end
    in_vld = 0; cyc();
    chk("str_drain", level, 0);
    chk("str_ovf",   ovf, 0);
    m_ready = 0;

    // async reset mid-stream with level=3 and ovf set
    in_vld = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h50 + i); cyc();
    end
    in_vld = 0; m_ready = 1; cyc();
    m_ready = 0;
    chk("pre_level", level, 3);
    chk("pre_ovf",   ovf, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_full",  full, 0);
    chk("arst_ovf",   ovf, 0);
`ifdef ALU_RES_FIFO_STATS_EN
    chk("arst_cnt", drop_cnt, 0);
`endif
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
